// File: rtl/instr_decode_stage.sv
// Registered MIPS-style instruction decoder between fetch and register-file read.
// The decode runs on the input word; an output register and a skid register form a 2-entry buffer.
module instr_decode_stage #(
   parameter int INSTR_W   = 32,
   parameter int REG_W     = 5,
   parameter int IMM_OUT_W = 32,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   instruction,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           fmt,
   output logic [5:0]           opcode,
   output logic [REG_W-1:0]     rs,
   output logic [REG_W-1:0]     rt,
   output logic [REG_W-1:0]     rd,
   output logic [4:0]           shamt,
   output logic [5:0]           funct,
   output logic [IMM_OUT_W-1:0] imm,
   output logic [25:0]          jtarget,
   output logic [CNT_W-1:0]     decode_cnt
);

   typedef enum logic [1:0] {
      FMT_R = 2'b00,
      FMT_I = 2'b01,
      FMT_J = 2'b10
   } fmt_e;

   typedef struct packed {
      fmt_e                 fmt;
      logic [5:0]           opcode;
      logic [REG_W-1:0]     rs;
      logic [REG_W-1:0]     rt;
      logic [REG_W-1:0]     rd;
      logic [4:0]           shamt;
      logic [5:0]           funct;
      logic [IMM_OUT_W-1:0] imm;
      logic [25:0]          jtarget;
   } decoded_t;

   // Fields a format does not use are forced to zero so downstream never sees stale bits.
   function automatic decoded_t decodeWord(input logic [INSTR_W-1:0] w);
      decoded_t d;
      d         = '0;
      d.opcode  = w[31:26];
      if (w[31:26] == 6'h00) begin
         d.fmt   = FMT_R;
         d.rs    = REG_W'(w[25:21]);
         d.rt    = REG_W'(w[20:16]);
         d.rd    = REG_W'(w[15:11]);
         d.shamt = w[10:6];
         d.funct = w[5:0];
      end else if (w[31:26] == 6'h02 || w[31:26] == 6'h03) begin
         d.fmt     = FMT_J;
         d.jtarget = w[25:0];
      end else begin
         d.fmt = FMT_I;
         d.rs  = REG_W'(w[25:21]);
         d.rt  = REG_W'(w[20:16]);
         if (w[31:26] == 6'h0C || w[31:26] == 6'h0D || w[31:26] == 6'h0E)
            d.imm = IMM_OUT_W'(w[15:0]);
         else
            d.imm = IMM_OUT_W'($signed(w[15:0]));
      end
      return d;
   endfunction

   decoded_t         w_dec;
   decoded_t         r_or;
   decoded_t         r_sk;
   logic             r_orValid;
   logic             r_skValid;
   logic             r_inReady;
   logic [CNT_W-1:0] r_cnt;

   logic w_accept;
   logic w_outHs;
   logic w_orLoadSk;
   logic w_orLoadIn;
   logic w_skLoad;
   logic w_orValidNext;
   logic w_skValidNext;

   // The skid register only fills while OR is stalled, so an accept never coincides with SK valid.
   always_comb begin
      w_dec         = decodeWord(instruction);
      w_accept      = in_valid & r_inReady;
      w_outHs       = r_orValid & out_ready;
      w_orLoadSk    = r_skValid & w_outHs;
      w_orLoadIn    = w_accept & (~r_orValid | w_outHs);
      w_skLoad      = w_accept & r_orValid & ~out_ready;
      w_orValidNext = w_orLoadSk | w_orLoadIn | (r_orValid & ~w_outHs);
      w_skValidNext = w_skLoad | (r_skValid & ~w_outHs);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_or      <= '0;
         r_sk      <= '0;
         r_orValid <= 1'b0;
         r_skValid <= 1'b0;
         r_inReady <= 1'b0;
         r_cnt     <= '0;
      end else if (flush) begin
         r_orValid <= 1'b0;
         r_skValid <= 1'b0;
         r_inReady <= 1'b1;
      end else begin
         r_orValid <= w_orValidNext;
         r_skValid <= w_skValidNext;
         r_inReady <= ~w_skValidNext;
         if (w_orLoadSk)
            r_or <= r_sk;
         else if (w_orLoadIn)
            r_or <= w_dec;
         if (w_skLoad)
            r_sk <= w_dec;
         if (w_outHs)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign in_ready   = r_inReady;
   assign out_valid  = r_orValid;
   assign fmt        = r_or.fmt;
   assign opcode     = r_or.opcode;
   assign rs         = r_or.rs;
   assign rt         = r_or.rt;
   assign rd         = r_or.rd;
   assign shamt      = r_or.shamt;
   assign funct      = r_or.funct;
   assign imm        = r_or.imm;
   assign jtarget    = r_or.jtarget;
   assign decode_cnt = r_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus a randomized run
// against a queue-based 2-entry FIFO model; a second instance with a 4-bit counter covers wrap.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid;
   logic [1:0]  fmt;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm;
   logic [25:0] jtarget;
   logic [15:0] decode_cnt;

   logic        s_inReady, s_outValid;
   logic [1:0]  s_fmt;
   logic [5:0]  s_opcode, s_funct;
   logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
   logic [31:0] s_imm;
   logic [25:0] s_jtarget;
   logic [3:0]  s_cnt;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [31:0] imm;
      logic [25:0] jt;
   } exp_t;

   instr_decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
      .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm(imm), .jtarget(jtarget), .decode_cnt(decode_cnt)
   );

   instr_decode_stage #(.CNT_W(4)) dutSmall (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_inReady),
      .instruction(instruction), .out_valid(s_outValid), .out_ready(out_ready),
      .fmt(s_fmt), .opcode(s_opcode), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_shamt),
      .funct(s_funct), .imm(s_imm), .jtarget(s_jtarget), .decode_cnt(s_cnt)
   );

   always #5 clk = ~clk;

   // Reference decode written straight from the field rules with shifts and arithmetic.
   function automatic exp_t refDecode(input logic [31:0] w);
      exp_t        e;
      int unsigned op;
      int unsigned u;
      e  = '0;
      u  = w;
      op = u / 67108864;
      e.op = 6'(op);
      if (op == 0) begin
         e.fmt = 2'd0;
         e.rs  = 5'((u >> 21) % 32);
         e.rt  = 5'((u >> 16) % 32);
         e.rd  = 5'((u >> 11) % 32);
         e.sh  = 5'((u >> 6) % 32);
         e.fn  = 6'(u % 64);
      end else if (op == 2 || op == 3) begin
         e.fmt = 2'd2;
         e.jt  = 26'(u % 67108864);
      end else begin
         e.fmt = 2'd1;
         e.rs  = 5'((u >> 21) % 32);
         e.rt  = 5'((u >> 16) % 32);
         e.imm = u % 65536;
         if (op != 12 && op != 13 && op != 14 && e.imm >= 32768)
            e.imm = e.imm + 32'hFFFF0000;
      end
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.fmt = fmt; o.op = opcode; o.rs = rs; o.rt = rt; o.rd = rd;
      o.sh = shamt; o.fn = funct; o.imm = imm; o.jt = jtarget;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
      in_valid    = v;
      instruction = w;
      out_ready   = ordy;
      flush       = fl;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({in_ready, out_valid} !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_handshake got=%b want=00", {in_ready, out_valid});
      end
      total++;
      if (observed() !== '0 || decode_cnt !== 16'd0) begin
         bad++; $display("[TB] FAIL reset_fields got=%h cnt=%0d want=0", observed(), decode_cnt);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_release_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_rtype();
      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || fmt !== 2'b00 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3 ||
          shamt !== 5'd0 || funct !== 6'h20 || imm !== 32'd0 || jtarget !== 26'd0) begin
         bad++; $display("[TB] FAIL rtype_fields got=v%b %h want fmt0 rs1 rt2 rd3 fn20", out_valid, observed());
      end
      tick();
      total++;
      if (decode_cnt !== 16'd1 || out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL rtype_count got=%0d v=%b want=1 v=0", decode_cnt, out_valid);
      end
   endtask

   task automatic test_itype();
      applyStimulus(1'b1, 32'h8C22FFFC, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h3422FFFC, 1'b1, 1'b0);
      total++;
      if (fmt !== 2'b01 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd0 || imm !== 32'hFFFFFFFC) begin
         bad++; $display("[TB] FAIL itype_sext got fmt=%b rs=%0d rt=%0d rd=%0d imm=%h want 01 1 2 0 fffffffc",
                         fmt, rs, rt, rd, imm);
      end
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || fmt !== 2'b01 || imm !== 32'h0000FFFC) begin
         bad++; $display("[TB] FAIL itype_zext got v=%b fmt=%b imm=%h want 1 01 0000fffc", out_valid, fmt, imm);
      end
      tick();
   endtask

   task automatic test_jtype();
      applyStimulus(1'b1, 32'h08000010, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      total++;
      if (fmt !== 2'b10 || jtarget !== 26'h0000010 || rs !== 5'd0 || rt !== 5'd0 ||
          rd !== 5'd0 || imm !== 32'd0) begin
         bad++; $display("[TB] FAIL jtype got=%h want fmt=10 jt=10 rest 0", observed());
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] startCnt;
      exp_t        want [3];
      want[0] = refDecode(32'h00221820);
      want[1] = refDecode(32'h8C22FFFC);
      want[2] = refDecode(32'h08000010);
      startCnt = decode_cnt;
      applyStimulus(1'b1, 32'h00221820, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h8C22FFFC, 1'b0, 1'b0);
      tick();
      total++;
      if (in_ready !== 1'b0 || observed() !== want[0]) begin
         bad++; $display("[TB] FAIL bp_full got rdy=%b or=%h want rdy=0 or=%h", in_ready, observed(), want[0]);
      end
      applyStimulus(1'b1, 32'h08000010, 1'b0, 1'b0);
      tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== want[0]) begin
         bad++; $display("[TB] FAIL bp_hold got rdy=%b v=%b or=%h want 0 1 %h", in_ready, out_valid, observed(), want[0]);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (out_valid !== 1'b1 || observed() !== want[k]) begin
            bad++; $display("[TB] FAIL bp_order%0d got v=%b %h want 1 %h", k, out_valid, observed(), want[k]);
         end
         tick();
         if (k == 1) in_valid = 1'b0;
      end
      total++;
      if (decode_cnt !== 16'(startCnt + 3) || out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL bp_count got=%0d v=%b want=%0d v=0", decode_cnt, out_valid, startCnt + 3);
      end
   endtask

   task automatic test_flush();
      logic [15:0] startCnt;
      startCnt = decode_cnt;
      applyStimulus(1'b1, 32'h00221820, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h8C22FFFC, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h08000010, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || decode_cnt !== startCnt) begin
         bad++; $display("[TB] FAIL flush got v=%b rdy=%b cnt=%0d want 0 1 %0d",
                         out_valid, in_ready, decode_cnt, startCnt);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL flush_drop got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_counter_wrap();
      doReset();
      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);
      for (int k = 0; k < 18; k++) tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if (s_cnt !== 4'd1 || decode_cnt !== 16'd17) begin
         bad++; $display("[TB] FAIL cnt_wrap got small=%0d main=%0d want 1 17", s_cnt, decode_cnt);
      end
   endtask

   task automatic test_random();
      exp_t        q[$];
      int unsigned cnt;
      logic        v, ordy, fl;
      logic [31:0] w;
      logic [5:0]  ops [8];
      ops = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h08};
      doReset();
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         total++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            bad++; $display("[TB] FAIL rnd_hs%0d got v=%b rdy=%b want v=%b rdy=%b",
                            i, out_valid, in_ready, q.size() > 0, q.size() < 2);
         end
         total++;
         if (decode_cnt !== 16'(cnt) || s_cnt !== 4'(cnt)) begin
            bad++; $display("[TB] FAIL rnd_cnt%0d got=%0d/%0d want=%0d", i, decode_cnt, s_cnt, cnt);
         end
         if (q.size() > 0) begin
            total++;
            if (observed() !== q[0]) begin
               bad++; $display("[TB] FAIL rnd_data%0d got=%h want=%h", i, observed(), q[0]);
            end
         end
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 24) == 0);
         w    = $urandom;
         if ($urandom_range(0, 1) == 1) w[31:26] = ops[$urandom_range(0, 7)];
         applyStimulus(v, w, ordy, fl);
         if (fl) begin
            q.delete();
         end else begin
            logic acc;
            acc = v && (q.size() < 2);
            if (ordy && q.size() > 0) begin
               void'(q.pop_front());
               cnt++;
            end
            if (acc) q.push_back(refDecode(w));
         end
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_rtype();
      test_itype();
      test_jtype();
      test_back_to_back();
      test_flush();
      test_counter_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
